second_largest_arbiter: RTL

//  Shares one largest/second-largest tracking engine among NUM_REQ requesters.

---
 rtl/second_largest_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/second_largest_arbiter.sv
// Round-robin arbiter sharing one largest/second-largest tracking engine among
// NUM_REQ frame producers; each granted frame yields one {largest, second} result.
module second_largest_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 8,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              grant,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   din,
  input  logic [NUM_REQ-1:0]              din_valid,
  output logic [NUM_REQ-1:0]              din_ready,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ID_WIDTH-1:0]             res_id,
  output logic [DATA_WIDTH-1:0]           res_largest,
  output logic [DATA_WIDTH-1:0]           res_second
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned NREQ = NUM_REQ;

  state_t                 state, state_n;
  logic [ID_WIDTH-1:0]    ptr;
  logic [LEN_WIDTH-1:0]   len, cnt;
  logic [DATA_WIDTH-1:0]  largest, second;

  logic                   any_req;
  logic [ID_WIDTH-1:0]    pick;
  logic [LEN_WIDTH-1:0]   pick_len;
  logic [DATA_WIDTH-1:0]  sample;
  logic                   beat;
  logic                   last_beat;

  // First requester strictly after ptr, wrapping, so the last winner ranks lowest.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any_req && req_valid[ID_WIDTH'(idx)]) begin
        any_req = 1'b1;
        pick    = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    pick_len = '0;
    sample   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == ID_WIDTH'(i))
        pick_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      if (res_id == ID_WIDTH'(i))
        sample = din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign din_ready   = (state == RUN) ? grant : '0;
  assign beat        = |(din_valid & din_ready);
  assign last_beat   = beat && (cnt == LEN_WIDTH'(len - 1'b1));
  assign res_valid   = (state == DONE);
  assign res_largest = largest;
  assign res_second  = second;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (any_req)   state_n = (pick_len != '0) ? RUN : DONE;
      RUN:  if (last_beat) state_n = DONE;
      DONE: if (res_ready) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant   <= '0;
      ptr     <= ID_WIDTH'(NUM_REQ - 1);
      len     <= '0;
      cnt     <= '0;
      res_id  <= '0;
      largest <= '0;
      second  <= '0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          len     <= pick_len;
          res_id  <= pick;
          cnt     <= '0;
          largest <= '0;
          second  <= '0;
          ptr     <= pick;
        end
        RUN: if (beat) begin
          if (sample > largest) begin
            second  <= largest;
            largest <= sample;
          end else if (sample > second) begin
            second <= sample;
          end
          cnt <= cnt + 1'b1;
        end
        DONE: if (res_ready) grant <= '0;
        default: ;
      endcase
    end
  end

endmodule
